// File: rtl/parallel_serial_comma_if.sv
// Byte-in / bit-out bus for the comma serializer.
//   DATA_IN, VALID_IN, READY_OUT : byte handshake into the 2-entry buffer
//   DATA_OUT, BYTE_START, IS_DATA: serial stream plus framing/qualifier flags
//   SYNC_DONE                    : preamble finished
// master = byte source / stream observer, slave = serializer.
interface parallel_serial_comma_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DATA_IN;
  logic             VALID_IN;
  logic             READY_OUT;
  logic             DATA_OUT;
  logic             BYTE_START;
  logic             IS_DATA;
  logic             SYNC_DONE;

  modport master (
    output DATA_IN, VALID_IN,
    input  READY_OUT, DATA_OUT, BYTE_START, IS_DATA, SYNC_DONE
  );

  modport slave (
    input  DATA_IN, VALID_IN,
    output READY_OUT, DATA_OUT, BYTE_START, IS_DATA, SYNC_DONE
  );
endinterface

// File: rtl/parallel_serial_comma.sv
// Transmit serializer for the comma-aligned receiver.
// Bytes arrive through a VALID/READY handshake into a 2-entry FIFO and leave
// LSB first, one bit per CLK. Every byte slot without payload carries COMMA,
// and after reset SYNC_COMMAS commas go out before any payload is allowed.
// Ports:
//   CLK   : rising-edge clock
//   RESET : asynchronous, active-low reset
//   bus   : slave side of parallel_serial_comma_if (handshake + serial out)
module parallel_serial_comma #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = 'hBC,
  parameter int               SYNC_COMMAS = 4
) (
  input logic                    CLK,
  input logic                    RESET,
  parallel_serial_comma_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            shift_q, shift_d;
  logic [CW-1:0]               bit_cnt_q, bit_cnt_d;
  logic [3:0]                  sync_cnt_q, sync_cnt_d;
  logic                        is_data_q, is_data_d;
  logic [1:0][WIDTH-1:0]       mem_q, mem_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0]                  count_q, count_d;

  logic load, push, pop, ready;

  // Ready looks only at the registered count, so a pop never reopens the
  // buffer in the same cycle.
  assign ready = (count_q < 2'd2);
  assign push  = bus.VALID_IN && ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    is_data_d  = is_data_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop        = 1'b0;
    load       = (bit_cnt_q == LAST);

    if (load) begin
      bit_cnt_d = '0;
      shift_d   = COMMA;
      is_data_d = 1'b0;
      if (state_q == ST_SYNC) begin
        // The comma loaded here is the sync_cnt_d-th preamble byte; once the
        // whole preamble is queued, payload may follow from the next slot.
        sync_cnt_d = sync_cnt_q + 4'd1;
        if (sync_cnt_d >= 4'(SYNC_COMMAS)) state_d = ST_RUN;
      end else if (count_q != 2'd0) begin
        // Only registered contents are eligible: a byte pushed on this very
        // edge waits for the next slot.
        pop       = 1'b1;
        shift_d   = mem_q[rd_ptr_q];
        is_data_d = 1'b1;
      end
    end else begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = bus.DATA_IN;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_SYNC;
      shift_q    <= COMMA;
      bit_cnt_q  <= '0;
      sync_cnt_q <= 4'd1;  // the comma loaded by reset is preamble byte 1
      is_data_q  <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      is_data_q  <= is_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign bus.READY_OUT  = ready;
  assign bus.DATA_OUT   = shift_q[0];
  assign bus.BYTE_START = (bit_cnt_q == '0);
  assign bus.IS_DATA    = is_data_q;
  assign bus.SYNC_DONE  = (state_q == ST_RUN);

endmodule

// File: doc/parallel_serial_comma.md
Name: parallel_serial_comma

Overview:
- Transmit-side serializer that feeds the comma-aligned serial-to-parallel receiver.
- Accepts 8-bit bytes through a VALID/READY handshake into a 2-entry buffer and shifts them out LSB first, one bit per CLK.
- Fills every byte slot that has no payload with the comma character (default 0xBC), so the receiver can acquire and keep byte alignment.
- After reset, sends a fixed preamble of commas before any payload is allowed out.

Parameters:
- WIDTH, 8, bits per serialized byte; the comma and data paths use this width.
- COMMA, 8'hBC, idle/alignment character sent in empty slots and in the preamble.
- SYNC_COMMAS, 4, number of comma bytes sent after reset before payload may be loaded; legal range 1..15.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- DATA_IN  input  WIDTH  payload byte.
- VALID_IN  input  1  DATA_IN is valid.
- READY_OUT  output  1  buffer can accept a byte this cycle; a byte transfers when VALID_IN and READY_OUT are both 1 at a CLK rising edge.
- DATA_OUT  output  1  serial bit; registered, equals SHIFT[0].
- BYTE_START  output  1  high on the cycle DATA_OUT carries bit 0 of a byte.
- IS_DATA  output  1  byte currently on DATA_OUT is payload (0 = comma).
- SYNC_DONE  output  1  preamble complete; stays 1 until the next reset.

Behaviour:
- Reset (RESET=0, asynchronous) sets these values:
  - SHIFT=COMMA, bit_cnt=0, sync_cnt=1 (the reset-loaded comma counts as preamble byte 1).
  - Buffer empty (count=0, read/write pointers 0), state=SYNC.
  - Outputs: DATA_OUT=COMMA[0]=0, BYTE_START=1, IS_DATA=0, SYNC_DONE=0, READY_OUT=1.
  - Reset asserted mid-byte abandons the byte and buffer contents immediately; no partial byte completes.
- Bit counter:
  - bit_cnt goes 0..WIDTH-1.
  - When bit_cnt<WIDTH-1: SHIFT shifts right by 1 and bit_cnt increments.
  - When bit_cnt=WIDTH-1 (load edge): SHIFT is loaded with the next byte and bit_cnt wraps to 0.
  - BYTE_START = (bit_cnt==0).
- State machine, two states:
  - SYNC: every load edge loads COMMA and increments sync_cnt. On the load edge where sync_cnt==SYNC_COMMAS, the state moves to RUN and SYNC_DONE is set. The byte loaded on that edge is still COMMA. The first payload can load at the following load edge: edge 8*SYNC_COMMAS cycles after reset release, i.e. cycle 32 at default.
  - RUN: each load edge pops the buffer head into SHIFT if count>0 (IS_DATA=1 for that byte); otherwise it loads COMMA (IS_DATA=0). RUN never returns to SYNC except via reset.
- Buffer:
  - 2-entry FIFO; READY_OUT = (count<2), computed from registered count only (no combinational path from the pop).
  - Writes are accepted in both states; bytes wait in the buffer during SYNC.
  - Push and pop on the same edge: count unchanged, ordering preserved.
  - Full (count=2) with a pop on this edge: READY_OUT is still 0 this cycle and rises the next cycle.
  - Empty buffer with a push on a load edge: no bypass. COMMA is loaded; the pushed byte goes out in the next slot.
  - VALID_IN while READY_OUT=0: no effect; the source must hold the data.
- Latency: a byte accepted into an empty buffer in RUN appears on DATA_OUT starting at the first BYTE_START at least 1 cycle after acceptance. Worst case is 8 cycles.
- Throughput: 1 byte per WIDTH cycles; back-to-back payload leaves no comma gaps while the buffer is non-empty.
- Bit order: LSB first, matching receiver fill order (bit 0 first, bit 7 last).
- pointers wrap modulo 2; count never exceeds 2 or underflows.

Test Plan:
- Reset release, VALID_IN=0 for 64 cycles -> DATA_OUT repeats 0,0,1,1,1,1,0,1 (0xBC LSB first) 8 times. SYNC_DONE rises on cycle 24 (the load edge with sync_cnt=4, at 8*(SYNC_COMMAS-1) cycles). IS_DATA=0 throughout.
- Push 0xA5 at cycle 2 -> byte slots 0-3 are comma; slot 4 (cycles 32-39) outputs 1,0,1,0,0,1,0,1 with IS_DATA=1; slot 5 reverts to comma.
- In RUN, push 0x01,0x02,0x03,0x04 with VALID_IN held high:
  - READY_OUT drops to 0 after 2 accepts and reopens one cycle after each pop.
  - Output slots carry 0x01,0x02,0x03,0x04 consecutively with no comma between them.
- Push on the exact load edge with the buffer empty (RUN) -> a comma is sent in that slot and the byte goes out in the next slot.
- Assert RESET=0 at bit 3 of a payload byte with 2 bytes buffered:
  - Outputs return to their reset values immediately and the buffer is flushed.
  - After release, a 4-comma preamble repeats and the flushed bytes are never emitted.
- Loopback into the receiver with random 200-byte stream and random VALID_IN gaps -> all payload bytes recovered in order; comma slots produce no payload.
